muntjac_fpu_round_arbiter: RTL and testbench
============================================

MUNTJAC_FPU_ROUND_ARBITER -- requirements
Module: muntjac_fpu_round_arbiter

Interface
REQ-001 Parameters SHALL be: NumReq, default 3, number of requesters; TagWidth, default 4, opaque tag width; InExpWidth, default 13, signed exponent width; InSigWidth, default 54, significand width; IeeeExpWidth, default 11, and IeeeSigWidth, default 52, target format.
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-low reset: clk_i input 1 (clock, rising edge); rst_ni input 1 (synchronous reset, active low).
REQ-003 req_valid_i input NumReq: per-requester valid.
REQ-004 req_ready_o output NumReq: per-requester ready; at most one bit set per cycle.
REQ-005 req_i input NumReq x round_req_t: per-requester payload carrying invalid, divide_by_zero, use_nan_payload, sign, is_zero, is_nan, is_inf, exponent (signed InExpWidth), significand (InSigWidth), rounding_mode and tag (TagWidth).
REQ-006 resp_valid_o output 1: registered result valid.
REQ-007 resp_ready_i input 1: consumer accepts the result.
REQ-008 resp_ieee_o output IeeeExpWidth+IeeeSigWidth+1: rounded IEEE result.
REQ-009 resp_flags_o output exception_flags_t: flags for this result.
REQ-010 resp_tag_o output TagWidth and resp_src_o output $clog2(NumReq): tag and index of the originating requester.
REQ-011 fflags_o output exception_flags_t: sticky OR of the flags of all delivered results.
REQ-012 fflags_clear_i input 1: clears the sticky flags.

Function
REQ-013 The block SHALL share one rounding datapath among NumReq requesters using round-robin arbitration.
REQ-014 Round-robin arbitration SHALL search upward from the priority pointer, wrapping modulo NumReq, for the first asserted req_valid_i.
REQ-015 The output stage SHALL be free when resp_valid_o=0, or when resp_valid_o=1 and resp_ready_i=1 in the same cycle.
REQ-016 req_ready_o[g] SHALL be 1 only for the granted index g, and only while the output stage is free.
REQ-017 No requester SHALL see ready while the output stage is held.
REQ-018 A request SHALL be accepted when req_valid_i[g]=1 and req_ready_o[g]=1.
REQ-019 The rounded result of an accepted request SHALL be registered, and resp_valid_o SHALL rise on the next edge, giving latency 1.
REQ-020 A full-throughput stream SHALL deliver one result per cycle.
REQ-021 While resp_valid_o=1 and resp_ready_i=0, all resp_* outputs SHALL hold stable.
REQ-022 A response transfer with no new acceptance in the same cycle SHALL clear resp_valid_o.
REQ-023 On acceptance from index g, the priority pointer SHALL become (g+1) mod NumReq; otherwise it SHALL be unchanged.
REQ-024 A requester that deasserts req_valid_i before acceptance SHALL lose its grant without side effect.
REQ-025 Rounding SHALL be combinational between the arbitration mux and the output register, with IEEE semantics: RNE/RTZ/RDN/RUP/RMM; overflow to inf or max-finite per mode; subnormal underflow detected after rounding; canonical NaN unless use_nan_payload is set.
REQ-026 On a response transfer (resp_valid_o and resp_ready_i), fflags_o SHALL be ORed with resp_flags_o.
REQ-027 fflags_clear_i alone SHALL set fflags_o to 0.
REQ-028 Clear together with a transfer in the same cycle SHALL set fflags_o to exactly resp_flags_o, so the transfer is not lost.
REQ-029 Results with zero flags SHALL leave fflags_o unchanged.

Reset
REQ-030 While rst_ni=0 at a rising edge, resp_valid_o SHALL become 0, the priority pointer 0, and fflags_o 0.
REQ-031 While rst_ni=0, req_ready_o SHALL be forced to all zeros.
REQ-032 resp_ieee_o, resp_flags_o, resp_tag_o and resp_src_o SHALL reset to 0.
REQ-033 A reset asserted while a result is held SHALL discard it, with no transfer and no fflags update.

Structure
REQ-034 round_req_t SHALL be defined in muntjac_fpu_pkg; rounding_mode_e and exception_flags_t SHALL be reused from that package.
REQ-035 The block SHALL instantiate exactly one muntjac_fpu_round_to_ieee as its shared datapath.
REQ-036 The arbiter SHALL be inline logic, not a separate sub-module.

Verification
REQ-037 Scenario: requester 0 sends exp 0, sig 0, RNE, binary64 -> one cycle later resp_ieee_o=0x3FF0000000000000, flags 0, resp_src_o=0.
REQ-038 Scenario: exp 1024, sign 0, RNE -> 0x7FF0000000000000, flags 0x05 (OF|NX); the same request with RTZ -> 0x7FEFFFFFFFFFFFFF.
REQ-039 Scenario: all three requesters valid continuously with resp_ready_i=1 -> grant order 0,1,2,0,1, one result per cycle, tags match.
REQ-040 Scenario: resp_ready_i held 0 for 3 cycles with a result pending -> all req_ready_o=0 and outputs stable; on release, transfer and new acceptance occur in the same cycle.
REQ-041 Scenario: fflags_o=0x01, then fflags_clear_i together with the transfer of a result with flags 0x10 (NV) -> fflags_o=0x10.
REQ-042 Scenario: rst_ni=0 for one cycle with resp_valid_o=1 -> resp_valid_o=0, fflags_o=0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/muntjac_fpu_pkg.sv
// muntjac_fpu_pkg: shared FPU types (rounding modes, exception flags, rounding request payload)
package muntjac_fpu_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rounding_mode_e;
  typedef struct packed {
    logic invalid_operation;
    logic divide_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } exception_flags_t;
  localparam int unsigned RoundExpWidth = 13;
  localparam int unsigned RoundSigWidth = 54;
  localparam int unsigned RoundTagWidth = 4;
  typedef struct packed {
    logic invalid;
    logic divide_by_zero;
    logic use_nan_payload;
    logic sign;
    logic is_zero;
    logic is_nan;
    logic is_inf;
    logic signed [RoundExpWidth-1:0] exponent;
    logic [RoundSigWidth-1:0] significand;
    rounding_mode_e rounding_mode;
    logic [RoundTagWidth-1:0] tag;
  } round_req_t;
endpackage

// File: rtl/muntjac_fpu_round_to_ieee.sv
// muntjac_fpu_round_to_ieee: combinational rounding of value 1.significand * 2^exponent to an IEEE format
// Ports: invalid_i/divide_by_zero_i pass-through flags; sign_i/is_*_i/exponent_i/significand_i operand;
// rounding_mode_i mode; ieee_o packed result; flags_o exception flags.
module muntjac_fpu_round_to_ieee
  import muntjac_fpu_pkg::*;
#(
  parameter int unsigned InExpWidth   = 13,
  parameter int unsigned InSigWidth   = 54,
  parameter int unsigned IeeeExpWidth = 11,
  parameter int unsigned IeeeSigWidth = 52
) (
  input  logic                                invalid_i,
  input  logic                                divide_by_zero_i,
  input  logic                                use_nan_payload_i,
  input  logic                                sign_i,
  input  logic                                is_zero_i,
  input  logic                                is_nan_i,
  input  logic                                is_inf_i,
  input  logic signed [InExpWidth-1:0]        exponent_i,
  input  logic [InSigWidth-1:0]               significand_i,
  input  rounding_mode_e                      rounding_mode_i,
  output logic [IeeeExpWidth+IeeeSigWidth:0]  ieee_o,
  output exception_flags_t                    flags_o
);
  localparam int unsigned EW = InExpWidth + 2;
  localparam int unsigned FW = InSigWidth + 1;
  localparam int unsigned KW = IeeeSigWidth + 1;
  localparam int unsigned RW = FW - KW;
  localparam int unsigned ShMax = FW;
  logic signed [EW-1:0] exp_b, sh_full, be, exp_r;
  logic [EW-1:0] sh;
  logic [FW+ShMax-1:0] ext;
  logic [KW-1:0] kept;
  logic [KW:0] sum;
  logic tiny, rnd, stk, nx, inc, ovf, to_inf, special;
  logic [IeeeExpWidth+IeeeSigWidth:0] inf_val, max_val, nan_val;
  assign exp_b = EW'(exponent_i) + EW'(2 ** (IeeeExpWidth - 1) - 1);
  // Tiny values are denormalised by shifting right; shifts past the whole mantissa only feed sticky.
  assign tiny = exp_b[EW-1] | ~|exp_b;
  assign sh_full = EW'(1) - exp_b;
  assign sh = !tiny ? '0 : (sh_full > EW'(ShMax)) ? EW'(ShMax) : sh_full;
  assign ext = {1'b1, significand_i, {ShMax{1'b0}}} >> sh;
  assign kept = ext[FW+ShMax-1 -: KW];
  assign rnd = ext[ShMax+RW-1];
  assign stk = |ext[ShMax+RW-2:0];
  assign nx = rnd | stk;
  assign inc = rounding_mode_i == RNE ? rnd & (stk | kept[0]) :
               rounding_mode_i == RDN ? sign_i & nx :
               rounding_mode_i == RUP ? ~sign_i & nx :
               rounding_mode_i == RMM ? rnd : 1'b0;
  assign sum = {1'b0, kept} + (KW+1)'(inc);
  // A carry out bumps the exponent; a subnormal that rounds up to the hidden bit becomes min-normal.
  assign be = tiny ? EW'(1) : exp_b;
  assign exp_r = sum[KW] ? be + EW'(1) : sum[KW-1] ? be : '0;
  assign ovf = exp_r >= EW'(2 ** IeeeExpWidth - 1);
  assign to_inf = rounding_mode_i == RNE | rounding_mode_i == RMM |
                  (rounding_mode_i == RDN & sign_i) | (rounding_mode_i == RUP & ~sign_i);
  assign special = is_nan_i | is_inf_i | is_zero_i;
  assign inf_val = {sign_i, {IeeeExpWidth{1'b1}}, {IeeeSigWidth{1'b0}}};
  assign max_val = {sign_i, {(IeeeExpWidth-1){1'b1}}, 1'b0, {IeeeSigWidth{1'b1}}};
  assign nan_val = use_nan_payload_i ?
    {sign_i, {IeeeExpWidth{1'b1}}, 1'b1, significand_i[InSigWidth-2 -: IeeeSigWidth-1]} :
    {1'b0, {IeeeExpWidth{1'b1}}, 1'b1, {(IeeeSigWidth-1){1'b0}}};
  assign ieee_o = is_nan_i ? nan_val : is_inf_i ? inf_val :
                  is_zero_i ? {sign_i, {(IeeeExpWidth+IeeeSigWidth){1'b0}}} :
                  ovf ? (to_inf ? inf_val : max_val) :
                  {sign_i, exp_r[IeeeExpWidth-1:0], sum[IeeeSigWidth-1:0]};
  // Underflow is judged on the rounded result: inexact and still subnormal or zero.
  assign flags_o = '{invalid_operation: invalid_i,
                     divide_by_zero:    divide_by_zero_i,
                     overflow:          ~special & ovf,
                     underflow:         ~special & ~ovf & nx & ~|exp_r,
                     inexact:           ~special & (ovf | nx)};
endmodule

// File: rtl/muntjac_fpu_round_arbiter.sv
// muntjac_fpu_round_arbiter: round-robin sharing of one rounding datapath with a registered output stage
// Ports: req_valid_i/req_ready_o/req_i per-requester handshake; resp_* registered result with tag and
// source index; fflags_o sticky flags of delivered results, cleared by fflags_clear_i.
module muntjac_fpu_round_arbiter
  import muntjac_fpu_pkg::*;
#(
  parameter int unsigned NumReq       = 3,
  parameter int unsigned TagWidth     = 4,
  parameter int unsigned InExpWidth   = 13,
  parameter int unsigned InSigWidth   = 54,
  parameter int unsigned IeeeExpWidth = 11,
  parameter int unsigned IeeeSigWidth = 52
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  round_req_t [NumReq-1:0]             req_i,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic [IeeeExpWidth+IeeeSigWidth:0]  resp_ieee_o,
  output exception_flags_t                    resp_flags_o,
  output logic [TagWidth-1:0]                 resp_tag_o,
  output logic [$clog2(NumReq)-1:0]           resp_src_o,
  output exception_flags_t                    fflags_o,
  input  logic                                fflags_clear_i
);
  localparam int unsigned SW = $clog2(NumReq);
  logic [SW-1:0] ptr_q, ptr_d, gnt_idx, cand, src_q;
  logic found, free, accept, xfer, valid_q;
  round_req_t sel;
  logic [IeeeExpWidth+IeeeSigWidth:0] ieee_d, ieee_q;
  exception_flags_t flags_d, flags_q, fflags_d, fflags_q;
  logic [TagWidth-1:0] tag_q;
  // Scan downward so the candidate closest above the pointer is the one that sticks.
  always_comb begin
    found = 1'b0;
    gnt_idx = ptr_q;
    cand = ptr_q;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = SW'((int'(ptr_q) + i) % NumReq);
      if (req_valid_i[cand]) begin
        found = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  assign free = ~valid_q | resp_ready_i;
  assign accept = rst_ni & free & found;
  assign xfer = valid_q & resp_ready_i;
  assign req_ready_o = accept ? NumReq'(1) << gnt_idx : '0;
  assign sel = req_i[gnt_idx];
  assign ptr_d = !accept ? ptr_q : gnt_idx == SW'(NumReq - 1) ? '0 : gnt_idx + SW'(1);
  assign fflags_d = exception_flags_t'((fflags_clear_i ? '0 : fflags_q) | (xfer ? flags_q : '0));
  muntjac_fpu_round_to_ieee #(
    .InExpWidth  (InExpWidth),
    .InSigWidth  (InSigWidth),
    .IeeeExpWidth(IeeeExpWidth),
    .IeeeSigWidth(IeeeSigWidth)
  ) u_round (
    .invalid_i        (sel.invalid),
    .divide_by_zero_i (sel.divide_by_zero),
    .use_nan_payload_i(sel.use_nan_payload),
    .sign_i           (sel.sign),
    .is_zero_i        (sel.is_zero),
    .is_nan_i         (sel.is_nan),
    .is_inf_i         (sel.is_inf),
    .exponent_i       (sel.exponent),
    .significand_i    (sel.significand),
    .rounding_mode_i  (sel.rounding_mode),
    .ieee_o           (ieee_d),
    .flags_o          (flags_d)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ptr_q <= '0;
      ieee_q <= '0;
      flags_q <= '0;
      tag_q <= '0;
      src_q <= '0;
      fflags_q <= '0;
    end else begin
      valid_q <= accept | (valid_q & ~resp_ready_i);
      ptr_q <= ptr_d;
      fflags_q <= fflags_d;
      if (accept) begin
        ieee_q <= ieee_d;
        flags_q <= flags_d;
        tag_q <= TagWidth'(sel.tag);
        src_q <= gnt_idx;
      end
    end
  end
  assign resp_valid_o = valid_q;
  assign resp_ieee_o = ieee_q;
  assign resp_flags_o = flags_q;
  assign resp_tag_o = tag_q;
  assign resp_src_o = src_q;
  assign fflags_o = fflags_q;
endmodule

// File: tb/tb_muntjac_fpu_round_arbiter.sv
// tb_muntjac_fpu_round_arbiter: directed and random checks of the round-robin rounding arbiter
module tb_muntjac_fpu_round_arbiter;
  import muntjac_fpu_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] valid, ready;
  round_req_t [N-1:0] req;
  logic resp_valid, resp_ready, clr;
  logic [63:0] ieee;
  exception_flags_t rflags, fflags;
  logic [3:0] tag;
  logic [1:0] src;
  int tests = 0, fails = 0;
  logic m_valid = 1'b0;
  logic [63:0] m_ieee = '0;
  logic [4:0] m_flags = '0, m_fflags = '0;
  logic [3:0] m_tag = '0;
  int m_src = 0, m_ptr = 0;
  int ord[5] = '{0, 1, 2, 0, 1};
  logic [68:0] pin;
  always #5 clk = ~clk;
  muntjac_fpu_round_arbiter #(.NumReq(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready), .req_i(req),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_ieee_o(ieee),
    .resp_flags_o(rflags), .resp_tag_o(tag), .resp_src_o(src), .fflags_o(fflags),
    .fflags_clear_i(clr)
  );
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic round_req_t mk(int e, logic [53:0] s, rounding_mode_e rm, logic [3:0] t);
    round_req_t r;
    r = '0;
    r.exponent = 13'(e);
    r.significand = s;
    r.rounding_mode = rm;
    r.tag = t;
    return r;
  endfunction
  // Reference: value = (2^54 + sig) * 2^(exp-54); quantise to the binary64 ulp at that magnitude.
  function automatic logic [68:0] ref_round(round_req_t r);
    longint e, fe;
    longint unsigned m, q, rem, half;
    int d;
    logic up, nx;
    logic [4:0] fl;
    logic [63:0] v;
    fl = {r.invalid, r.divide_by_zero, 3'b000};
    if (r.is_nan) v = r.use_nan_payload ? {r.sign, 11'h7ff, 1'b1, r.significand[52:2]} : 64'h7ff8000000000000;
    else if (r.is_inf) v = {r.sign, 11'h7ff, 52'h0};
    else if (r.is_zero) v = {r.sign, 63'h0};
    else begin
      e = longint'(r.exponent);
      m = (64'd1 << 54) | 64'(r.significand);
      d = int'((e > -1022 ? e : -1022) - e + 2);
      if (d > 60) begin
        q = 0; rem = 1; half = 2;
      end else begin
        q = m >> d; rem = m - (q << d); half = 64'd1 << (d - 1);
      end
      nx = rem != 0;
      if (r.rounding_mode == RNE) up = rem > half || (rem == half && (q & 1) != 0);
      else if (r.rounding_mode == RDN) up = r.sign && nx;
      else if (r.rounding_mode == RUP) up = !r.sign && nx;
      else if (r.rounding_mode == RMM) up = rem >= half;
      else up = 1'b0;
      q = q + 64'(up);
      if (e >= -1022) begin
        fe = e + 1023;
        if (q == (64'd1 << 53)) begin fe++; q = 64'd1 << 52; end
      end else fe = (q == (64'd1 << 52)) ? 1 : 0;
      if (fe >= 2047) begin
        fl = fl | 5'b00101;
        if (r.rounding_mode == RNE || r.rounding_mode == RMM ||
            (r.rounding_mode == RDN && r.sign) || (r.rounding_mode == RUP && !r.sign))
          v = {r.sign, 11'h7ff, 52'h0};
        else v = {r.sign, 11'h7fe, {52{1'b1}}};
      end else begin
        v = {r.sign, 11'(fe), 52'(q)};
        if (nx) fl = fl | 5'b00001;
        if (nx && fe == 0) fl = fl | 5'b00010;
      end
    end
    return {fl, v};
  endfunction
  function automatic round_req_t rand_req();
    round_req_t r;
    int k;
    logic [53:0] s;
    r = '0;
    r.invalid = $urandom_range(0, 7) == 0;
    r.divide_by_zero = $urandom_range(0, 7) == 0;
    r.use_nan_payload = 1'($urandom);
    r.sign = 1'($urandom);
    k = $urandom_range(0, 9);
    r.is_nan = k == 0;
    r.is_inf = k == 1;
    r.is_zero = k == 2;
    k = $urandom_range(0, 3);
    r.exponent = k == 0 ? 13'(int'($urandom_range(0, 62)) - 1080) :
                 k == 1 ? 13'(int'($urandom_range(1019, 1026))) : 13'(int'($urandom_range(0, 40)) - 20);
    s = 54'({$urandom, $urandom});
    k = $urandom_range(0, 3);
    if (k == 0) s = '1;
    else if (k == 1) s = {s[53:2], 2'b10};
    r.significand = s;
    r.rounding_mode = rounding_mode_e'($urandom_range(0, 4));
    r.tag = 4'($urandom);
    return r;
  endfunction
  // Called at a falling edge with inputs set: checks ready, advances the model and DUT one cycle.
  task automatic tick();
    int g;
    logic [N-1:0] er;
    logic xfer;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = '0;
    if (rst_n && (!m_valid || resp_ready) && g >= 0) er[g] = 1'b1;
    chk("req_ready", ready, er);
    if (!rst_n) begin
      m_valid = 0; m_ptr = 0; m_fflags = 0; m_ieee = 0; m_flags = 0; m_tag = 0; m_src = 0;
    end else begin
      xfer = m_valid && resp_ready;
      if (clr) m_fflags = 0;
      if (xfer) m_fflags = m_fflags | m_flags;
      if (er != 0) begin
        {m_flags, m_ieee} = ref_round(req[g]);
        m_tag = req[g].tag;
        m_src = g;
        m_valid = 1;
        m_ptr = (g + 1) % N;
      end else if (xfer) m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      chk("resp_ieee", ieee, m_ieee);
      chk("resp_flags", rflags, m_flags);
      chk("resp_tag", tag, m_tag);
      chk("resp_src", src, m_src);
    end
    chk("fflags", fflags, m_fflags);
  endtask
  initial begin
    valid = '0; req = '0; resp_ready = 1'b0; clr = 1'b0;
    pin = ref_round(mk(0, 0, RNE, 0));          chk("pin_one", pin, {5'h00, 64'h3FF0000000000000});
    pin = ref_round(mk(1024, 0, RNE, 0));       chk("pin_ovf_rne", pin, {5'h05, 64'h7FF0000000000000});
    pin = ref_round(mk(1024, 0, RTZ, 0));       chk("pin_ovf_rtz", pin, {5'h05, 64'h7FEFFFFFFFFFFFFF});
    pin = ref_round(mk(-1075, 0, RNE, 0));      chk("pin_tie_zero", pin, {5'h03, 64'h0});
    pin = ref_round(mk(-1075, 0, RUP, 0));      chk("pin_tie_rup", pin, {5'h03, 64'h1});
    pin = ref_round(mk(0, 3, RNE, 0));          chk("pin_round_up", pin, {5'h01, 64'h3FF0000000000001});
    pin = ref_round(mk(0, '1, RNE, 0));         chk("pin_carry", pin, {5'h01, 64'h4000000000000000});
    pin = ref_round(mk(-1023, 0, RNE, 0));      chk("pin_subnormal", pin, {5'h00, 64'h0008000000000000});
    @(negedge clk);
    tick();
    tick();
    chk("rst_valid", resp_valid, 0); chk("rst_ieee", ieee, 0); chk("rst_flags", rflags, 0);
    chk("rst_tag", tag, 0); chk("rst_src", src, 0); chk("rst_fflags", fflags, 0);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    req[0] = mk(0, 0, RNE, 4'h1); valid = 3'b001; tick();
    chk("s37_ieee", ieee, 64'h3FF0000000000000); chk("s37_flags", rflags, 0); chk("s37_src", src, 0);
    req[1] = mk(1024, 0, RNE, 4'h2); valid = 3'b010; tick();
    chk("s38_rne", ieee, 64'h7FF0000000000000); chk("s38_flags", rflags, 5'h05);
    req[2] = mk(1024, 0, RTZ, 4'h3); valid = 3'b100; tick();
    chk("s38_rtz", ieee, 64'h7FEFFFFFFFFFFFFF);
    valid = '0; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clear_only", fflags, 0);
    req[0] = mk(0, 3, RNE, 4'h4); valid = 3'b001; tick();
    valid = '0; tick();
    chk("s41_pre", fflags, 5'h01);
    req[1] = mk(0, 0, RNE, 4'h5); req[1].is_nan = 1'b1; req[1].invalid = 1'b1; valid = 3'b010; tick();
    valid = '0; clr = 1'b1; tick(); clr = 1'b0;
    chk("s41_clear_xfer", fflags, 5'h10);
    req[2] = mk(5, 0, RNE, 4'h6); valid = 3'b100; tick();
    valid = '0; tick();
    chk("zero_flags_keep", fflags, 5'h10);
    for (int i = 0; i < N; i++) req[i] = rand_req();
    valid = '1; tick();
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_ready", ready, 0);
      tick();
    end
    resp_ready = 1'b1; tick();
    chk("release_valid", resp_valid, 1);
    valid = '0; rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("s42_valid", resp_valid, 0); chk("s42_fflags", fflags, 0);
    for (int i = 0; i < N; i++) req[i] = mk(i, 0, RNE, 4'(8 + i));
    valid = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_src", src, ord[k]);
      chk("rr_tag", tag, 8 + ord[k]);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 2) != 0) req[i] = rand_req();
      valid = N'($urandom);
      resp_ready = $urandom_range(0, 9) < 7;
      clr = $urandom_range(0, 19) == 0;
      rst_n = $urandom_range(0, 99) != 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
